// File: rtl/load_ctrl_if.sv
// Button/switch inputs and strobe/data outputs of the load controller.
`timescale 1ns/1ps
interface load_ctrl_if;
  logic       LC_BTN_LOAD;
  logic       LC_BTN_CLR;
  logic       LC_BTN_SET;
  logic [7:0] LC_SW;
  logic [7:0] LC_D;
  logic       LC_E;
  logic       LC_C;
  logic       LC_SET;
  logic       LC_BUSY;

  // Front-panel side: drives raw buttons/switches, observes strobes.
  modport master (
    output LC_BTN_LOAD, LC_BTN_CLR, LC_BTN_SET, LC_SW,
    input  LC_D, LC_E, LC_C, LC_SET, LC_BUSY
  );

  // Controller side.
  modport slave (
    input  LC_BTN_LOAD, LC_BTN_CLR, LC_BTN_SET, LC_SW,
    output LC_D, LC_E, LC_C, LC_SET, LC_BUSY
  );
endinterface

// File: rtl/load_ctrl.sv
// load_ctrl: debounces load/clear/set pushbuttons and issues one registered
// strobe per press (load > clear > set), capturing the switch operand.
// Optional feature macro: LC_BTN_SYNC_EN adds a two-flop synchronizer per
// button ahead of its debounce counter (two extra edges of latency).
`timescale 1ns/1ps
module load_ctrl #(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic        LC_CLK,
  input  logic        LC_RST_N,
  load_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned N_BTN    = 3;
  localparam int unsigned BTN_LOAD = 0;
  localparam int unsigned BTN_CLR  = 1;
  localparam int unsigned BTN_SET  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  logic [N_BTN-1:0] raw_btn;
  logic [N_BTN-1:0] cond_btn;
  logic [N_BTN-1:0] lvl_q;
  logic [CNT_W-1:0] cnt_q [N_BTN];

  state_t     state_q, state_d;
  logic       e_q, c_q, set_q, busy_q;
  logic       e_d, c_d, set_d, capture;
  logic [7:0] d_q;

  assign raw_btn = {bus.LC_BTN_SET, bus.LC_BTN_CLR, bus.LC_BTN_LOAD};

`ifdef LC_BTN_SYNC_EN
  logic [N_BTN-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge LC_CLK or negedge LC_RST_N) begin
    if (!LC_RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_btn;
      sync2_q <= sync1_q;
    end
  end

  assign cond_btn = sync2_q;
`else
  assign cond_btn = raw_btn;
`endif

  // Debounce: level flips after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge LC_CLK or negedge LC_RST_N) begin
    if (!LC_RST_N) begin
      lvl_q <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (cond_btn[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
          lvl_q[i] <= ~lvl_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge LC_CLK or negedge LC_RST_N) begin
    if (!LC_RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next strobe values; the winner is chosen on leaving IDLE.
  always_comb begin
    state_d = state_q;
    e_d     = 1'b0;
    c_d     = 1'b0;
    set_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (|lvl_q) begin
          state_d = ISSUE;
          capture = 1'b1;
          e_d     = lvl_q[BTN_LOAD];
          c_d     = !lvl_q[BTN_LOAD] && lvl_q[BTN_CLR];
          set_d   = !lvl_q[BTN_LOAD] && !lvl_q[BTN_CLR] && lvl_q[BTN_SET];
        end
      end
      ISSUE: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (~|lvl_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered strobes, busy flag and operand capture.
  always_ff @(posedge LC_CLK or negedge LC_RST_N) begin
    if (!LC_RST_N) begin
      e_q    <= 1'b0;
      c_q    <= 1'b0;
      set_q  <= 1'b0;
      busy_q <= 1'b0;
      d_q    <= 8'h00;
    end else begin
      e_q    <= e_d;
      c_q    <= c_d;
      set_q  <= set_d;
      busy_q <= (state_d != IDLE);
      if (capture) begin
        d_q <= bus.LC_SW;
      end
    end
  end

  assign bus.LC_D    = d_q;
  assign bus.LC_E    = e_q;
  assign bus.LC_C    = c_q;
  assign bus.LC_SET  = set_q;
  assign bus.LC_BUSY = busy_q;

endmodule

// File: tb/tb_load_ctrl.sv
// Directed bench for load_ctrl with DB_CYCLES=4; strobe latency follows
// whether LC_BTN_SYNC_EN is defined for the build.
`timescale 1ns/1ps
module tb_load_ctrl;

  localparam int unsigned DB = 4;
`ifdef LC_BTN_SYNC_EN
  localparam int LAT = DB + 3;
`else
  localparam int LAT = DB + 1;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   e_cnt, c_cnt, s_cnt;

  load_ctrl_if bus ();

  load_ctrl #(.DB_CYCLES(DB)) dut (
    .LC_CLK   (clk),
    .LC_RST_N (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_strobes(input string tag);
    chk({tag, "_e"},   8'(bus.LC_E),   8'h0);
    chk({tag, "_c"},   8'(bus.LC_C),   8'h0);
    chk({tag, "_set"}, 8'(bus.LC_SET), 8'h0);
  endtask

  task automatic count_strobes();
    e_cnt += int'(bus.LC_E);
    c_cnt += int'(bus.LC_C);
    s_cnt += int'(bus.LC_SET);
    chk("one_hot", 8'(int'(bus.LC_E) + int'(bus.LC_C) + int'(bus.LC_SET) <= 1), 8'h1);
  endtask

  // Release everything and confirm busy drops exactly LAT edges later.
  task automatic release_all(input string tag);
    bus.LC_BTN_LOAD = 1'b0;
    bus.LC_BTN_CLR  = 1'b0;
    bus.LC_BTN_SET  = 1'b0;
    for (int r = 1; r <= LAT + 3; r++) begin
      tick();
      count_strobes();
      chk({tag, "_rel_busy"}, 8'(bus.LC_BUSY), 8'(r < LAT));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    e_cnt = 0; c_cnt = 0; s_cnt = 0;
    rst_n = 1'b0;
    bus.LC_BTN_LOAD = 1'b0;
    bus.LC_BTN_CLR  = 1'b0;
    bus.LC_BTN_SET  = 1'b0;
    bus.LC_SW       = 8'h00;

    // Reset state.
    tick(); tick();
    chk("rst_d", bus.LC_D, 8'h00);
    chk("rst_busy", 8'(bus.LC_BUSY), 8'h0);
    chk_idle_strobes("rst");
    rst_n = 1'b1;
    tick(); tick();

    // Clean load press; switch changes after capture must be ignored.
    bus.LC_SW = 8'hA5;
    bus.LC_BTN_LOAD = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) bus.LC_SW = 8'h3C;
      chk("press_e",    8'(bus.LC_E),    8'(k == LAT));
      chk("press_busy", 8'(bus.LC_BUSY), 8'(k >= LAT));
      chk("press_d",    bus.LC_D,        (k >= LAT) ? 8'hA5 : 8'h00);
      chk("press_c",    8'(bus.LC_C),    8'h0);
      chk("press_set",  8'(bus.LC_SET),  8'h0);
    end
    release_all("press");
    chk("press_d_hold", bus.LC_D, 8'hA5);

    // Bouncing clear button: pulses of 1-3 cycles never debounce.
    begin
      int dur [14] = '{1, 1, 2, 2, 3, 1, 3, 2, 1, 3, 2, 3, 3, 3};
      logic lvl;
      lvl = 1'b1;
      for (int p = 0; p < 14; p++) begin
        bus.LC_BTN_CLR = lvl;
        for (int q = 0; q < dur[p]; q++) begin
          tick();
          chk("bounce_busy", 8'(bus.LC_BUSY), 8'h0);
          chk_idle_strobes("bounce");
        end
        lvl = ~lvl;
      end
    end
    bus.LC_BTN_CLR = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("bounce_tail_busy", 8'(bus.LC_BUSY), 8'h0);
      chk_idle_strobes("bounce_tail");
    end

    // Clear and set together: clear wins, set never fires.
    e_cnt = 0; c_cnt = 0; s_cnt = 0;
    bus.LC_BTN_CLR = 1'b1;
    bus.LC_BTN_SET = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      count_strobes();
      chk("prio_c_at", 8'(bus.LC_C), 8'(k == LAT));
    end
    release_all("prio");
    chk("prio_c_cnt", 8'(c_cnt), 8'd1);
    chk("prio_set_cnt", 8'(s_cnt), 8'd0);
    chk("prio_e_cnt", 8'(e_cnt), 8'd0);
    chk("prio_d", bus.LC_D, 8'h3C);

    // Long set press gives one pulse; a second press gives another.
    e_cnt = 0; c_cnt = 0; s_cnt = 0;
    bus.LC_SW = 8'h5A;
    bus.LC_BTN_SET = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      count_strobes();
    end
    release_all("rep1");
    chk("rep_first_cnt", 8'(s_cnt), 8'd1);
    chk("rep_d", bus.LC_D, 8'h5A);
    bus.LC_BTN_SET = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      count_strobes();
      chk("rep2_set_at", 8'(bus.LC_SET), 8'(k == LAT));
    end
    release_all("rep2");
    chk("rep_second_cnt", 8'(s_cnt), 8'd2);
    chk("rep_other_cnt", 8'(e_cnt + c_cnt), 8'd0);

    // Reset pulsed during ISSUE with load still held.
    bus.LC_SW = 8'hC3;
    bus.LC_BTN_LOAD = 1'b1;
    for (int k = 1; k <= LAT; k++) tick();
    chk("mid_issue_e", 8'(bus.LC_E), 8'h1);
    chk("mid_issue_d", bus.LC_D, 8'hC3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_e", 8'(bus.LC_E), 8'h0);
    chk("mid_rst_d", bus.LC_D, 8'h00);
    chk("mid_rst_busy", 8'(bus.LC_BUSY), 8'h0);
    tick();
    chk("mid_rst_hold_e", 8'(bus.LC_E), 8'h0);
    rst_n = 1'b1;
    e_cnt = 0; c_cnt = 0; s_cnt = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      count_strobes();
      chk("mid_post_e", 8'(bus.LC_E), 8'(k == LAT));
      chk("mid_post_d", bus.LC_D, (k >= LAT) ? 8'hC3 : 8'h00);
    end
    release_all("mid");
    chk("mid_e_cnt", 8'(e_cnt), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_ctrl.md
LOAD_CTRL -- requirements
Module: load_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 250000, is the number of consecutive stable cycles a button must hold before its debounced level changes; legal values are 1 and above.
REQ-002 LC_CLK  input  1  is the single system clock, and all state updates on its rising edge.
REQ-003 LC_RST_N  input  1  is the reset, which is asynchronous and active-low.
REQ-004 LC_BTN_LOAD  input  1  is the raw, asynchronous, bouncing load pushbutton.
REQ-005 LC_BTN_CLR  input  1  is the raw clear pushbutton.
REQ-006 LC_BTN_SET  input  1  is the raw set pushbutton.
REQ-007 LC_SW  input  8  is the raw slide-switch operand value.
REQ-008 LC_D  output  8  is the captured operand, which feeds the downstream 8-bit register data input.
REQ-009 LC_E  output  1  is a one-cycle load strobe to the downstream register enable.
REQ-010 LC_C  output  1  is a one-cycle clear strobe.
REQ-011 LC_SET  output  1  is a one-cycle set strobe.
REQ-012 LC_BUSY  output  1  is high in every state except IDLE.

Function
REQ-013 Each button has its own conditioning path: an optional synchronizer (see Configuration), then a debounce counter, then a debounced level register.
REQ-014 Debounce counter behaviour:
  - It clears whenever the conditioned input equals the debounced level.
  - Otherwise it increments by one per cycle.
  - On the edge where it reaches DB_CYCLES, the debounced level toggles and the counter clears.
REQ-015 Counter width is ceil(log2(DB_CYCLES+1)) bits, and the counter never wraps.
REQ-016 The FSM has three states: IDLE, ISSUE and WAIT_REL.
REQ-017 IDLE -> ISSUE on the edge after any debounced level is high; at that same edge LC_SW is captured into LC_D.
REQ-018 ISSUE lasts exactly one cycle, asserting exactly one strobe from a registered output. Priority applies when several debounced levels are high: load, then clear, then set.
REQ-019 LC_C and LC_SET are asserted only when the load button is not the winner; at most one of LC_E, LC_C and LC_SET is ever high.
REQ-020 ISSUE -> WAIT_REL unconditionally.
REQ-021 WAIT_REL -> IDLE on the edge after all three debounced levels are low.
REQ-022 Further presses while in ISSUE or WAIT_REL produce no strobe, so each strobe requires a full release first.
REQ-023 LC_D holds its value between captures and changes only on the IDLE -> ISSUE edge; switch changes at any other time are ignored.
REQ-024 Any raw pulse or glitch shorter than DB_CYCLES cycles after conditioning produces no strobe and leaves the FSM state unchanged.

Reset
REQ-025 While LC_RST_N is low, the following are forced immediately and asynchronously:
  - FSM state to IDLE;
  - LC_D to 8'h00;
  - LC_E, LC_C, LC_SET and LC_BUSY to 0;
  - all debounce counters, debounced levels and synchronizer flops to 0.
REQ-026 If reset is asserted in ISSUE, the strobe deasserts within the reset assertion, with no partial pulse held afterwards.
REQ-027 A button still held when LC_RST_N deasserts is treated as a new press: it produces one strobe after full debounce latency.

Configuration
REQ-028 Macro LC_BTN_SYNC_EN controls input synchronization of the three buttons.
  - Defined: each button passes through a two-flop synchronizer, and the first strobe appears DB_CYCLES+3 edges after the first edge sampling the raw button high (for a clean press).
  - Undefined: buttons feed the debounce counters directly, and latency is DB_CYCLES+1 edges.
REQ-029 LC_SW is never synchronized under either setting; it is captured only after at least DB_CYCLES stable button cycles.

Verification (DB_CYCLES=4, LC_BTN_SYNC_EN defined)
REQ-030 Clean press: LC_SW=8'hA5, LC_BTN_LOAD held high for 20 cycles -> LC_D=8'hA5, and LC_E high for exactly one cycle 7 edges after first sample. LC_BUSY stays high until 7 edges after release.
REQ-031 Bounce: LC_BTN_CLR toggles with pulses of 1-3 cycles for 30 cycles, then goes low -> no strobe, LC_BUSY stays 0.
REQ-032 Priority: LC_BTN_CLR and LC_BTN_SET rise on the same cycle and are held for 10 cycles -> LC_C pulses once, and LC_SET never asserts.
REQ-033 Repeat lockout: LC_BTN_SET held for 50 cycles -> exactly one LC_SET pulse; after release, a second press gives a second pulse.
REQ-034 Mid-operation reset: LC_RST_N pulsed low for 1 cycle during ISSUE with LC_BTN_LOAD still held -> LC_E drops, LC_D=8'h00, and one new LC_E pulse appears 7 edges after reset release.
REQ-035 Macro undefined: repeat REQ-030 -> the LC_E pulse appears 5 edges after the first sample.
